// File: rtl/shared_exp_pkg.sv
// Shared types and constants for the shared-expression scheduler.
package shared_exp_pkg;

  localparam int unsigned OPW     = 5;
  localparam int unsigned IDW_MAX = 4;

  localparam int unsigned A_BIT = 4;
  localparam int unsigned B_BIT = 3;
  localparam int unsigned C_BIT = 2;
  localparam int unsigned D_BIT = 1;
  localparam int unsigned E_BIT = 0;

  // Stage-1 payload: operand word plus owning requester
  typedef struct packed {
    logic [OPW-1:0]     ops;
    logic [IDW_MAX-1:0] id;
  } s1_t;

endpackage

// File: rtl/shared_exp_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from a rotating priority pointer.
module shared_exp_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IXW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            en,
  input  logic            upd,
  output logic [NREQ-1:0] grant_c,
  output logic [IXW-1:0]  idx_c,
  output logic            any_c
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [IXW-1:0] ptr;
  int unsigned    cand;

  // First valid requester at or after the pointer, wrapping modulo NREQ
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      if (en && !any_c && valid[PW'(cand)]) begin
        any_c              = 1'b1;
        grant_c[PW'(cand)] = 1'b1;
        idx_c              = IXW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (upd) begin
      ptr <= (idx_c == IXW'(NREQ - 1)) ? '0 : idx_c + IXW'(1);
    end
  end

endmodule

// File: rtl/shared_exp_sched.sv
// Shares one shared-expression evaluator between NREQ requesters through a
// round-robin arbiter and a two-stage backpressurable pipeline.
module shared_exp_sched
  import shared_exp_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  output logic                res_q,
  output logic [IDW-1:0]      res_id,
  input  logic                res_ready,
  output logic                busy,
  output logic [CNTW-1:0]     done_cnt
);

  logic                s1_valid;
  s1_t                 s1_q;
  logic                s1_en;
  logic                s2_en;
  logic                s1_nxt;
  logic                s2_nxt;
  logic [NREQ-1:0]     grant_c;
  logic [IDW_MAX-1:0]  arb_idx_c;
  logic                arb_any_c;
  logic [OPW-1:0]      ops_sel_c;
  logic                ab_c;
  logic                q_c;
  logic                unused_c;

  assign s2_en = ~res_valid | res_ready;
  assign s1_en = ~s1_valid | s2_en;

  // Grants are suppressed while reset is held so req_ready reads zero
  shared_exp_rr_arb #(
    .NREQ (NREQ),
    .IXW  (IDW_MAX)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .en      (s1_en & rst_n),
    .upd     (arb_any_c),
    .grant_c (grant_c),
    .idx_c   (arb_idx_c),
    .any_c   (arb_any_c)
  );

  assign req_ready = grant_c;

  // Operand mux driven by the one-hot grant, never by req_data itself
  always_comb begin
    ops_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        ops_sel_c = req_data[i*OPW +: OPW];
      end
    end
  end

  assign ab_c = s1_q.ops[A_BIT] | s1_q.ops[B_BIT];
  assign q_c  = ((ab_c & s1_q.ops[C_BIT]) | ab_c | s1_q.ops[D_BIT]) & ~ab_c;

  assign s1_nxt = s1_en ? arb_any_c : s1_valid;
  assign s2_nxt = s2_en ? s1_valid : res_valid;

  assign unused_c = ^{s1_q.ops[E_BIT], s1_q.id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      res_valid <= 1'b0;
      res_q     <= 1'b0;
      res_id    <= '0;
      busy      <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= arb_any_c;
        if (arb_any_c) begin
          s1_q <= '{ops: ops_sel_c, id: arb_idx_c};
        end
      end
      if (s2_en) begin
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_q  <= q_c;
          res_id <= IDW'(s1_q.id);
        end
      end
      busy <= s1_nxt | s2_nxt;
      if (res_valid && res_ready) begin
        done_cnt <= done_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shared_exp_sched.sv
// Randomized scoreboard bench for shared_exp_sched against a behavioural model.
module tb_shared_exp_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CNTW = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*5-1:0]   req_data;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic                res_q;
  logic [IDW-1:0]      res_id;
  logic                res_ready;
  logic                busy;
  logic [CNTW-1:0]     done_cnt;

  always #5 clk = ~clk;

  shared_exp_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_q     (res_q),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  typedef struct {
    int   id;
    logic q;
    int   acc;
  } item_t;

  item_t           sb[$];
  logic [4:0]      pend[NREQ][$];
  int              total = 0;
  int              bad = 0;
  int              ptr_m = 0;
  int              edge_cnt = 0;
  logic [CNTW-1:0] done_m = '0;
  logic [NREQ-1:0] last_hs = '0;
  logic            prev_stall = 1'b0;
  logic            prev_q = 1'b0;
  logic [IDW-1:0]  prev_id = '0;
  logic [NREQ-1:0] exp_g;
  logic [NREQ-1:0] hs;
  item_t           it;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first valid requester from the model pointer, if the pipe can take one
  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input bit ok);
    logic [NREQ-1:0] g = '0;
    if (ok) begin
      for (int k = 0; k < NREQ; k++) begin
        int c = (ptr_m + k) % NREQ;
        if (v[c]) begin
          g[c] = 1'b1;
          return g;
        end
      end
    end
    return g;
  endfunction

  // Monitor/scoreboard: checks mid-cycle, then applies the coming edge's handshakes
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      chk("rst_res_q", 32'(res_q), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      sb.delete();
      ptr_m      = 0;
      done_m     = '0;
      last_hs    = '0;
      prev_stall = 1'b0;
      edge_cnt   = 0;
    end else begin
      exp_g = model_grant(req_valid, (sb.size() < 2) || res_ready);
      chk("req_ready", 32'(req_ready), 32'(exp_g));
      chk("res_valid", 32'(res_valid), 32'(sb.size() > 0 && sb[0].acc < edge_cnt));
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      chk("done_cnt", 32'(done_cnt), 32'(done_m));
      if (prev_stall) begin
        chk("stall_res_q", 32'(res_q), 32'(prev_q));
        chk("stall_res_id", 32'(res_id), 32'(prev_id));
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_result: got id %0d want none at t=%0t", res_id, $time);
        end else begin
          it = sb.pop_front();
          chk("res_id", 32'(res_id), 32'(it.id));
          chk("res_q", 32'(res_q), 32'(it.q));
        end
        done_m = done_m + 1'b1;
      end
      hs = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          logic [4:0] w;
          w = req_data[i*5 +: 5];
          sb.push_back('{id: i, q: w[1] & ~w[4] & ~w[3], acc: edge_cnt + 1});
          ptr_m = (i + 1) % NREQ;
        end
      end
      last_hs    = hs;
      prev_stall = res_valid && !res_ready;
      prev_q     = res_q;
      prev_id    = res_id;
      edge_cnt++;
    end
  end

  // One driver cycle: retire accepted words, present the next, set res_ready by mode
  task automatic cycle(input bit gaps, input int mode, input int n);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      bit held;
      if (last_hs[i] && pend[i].size() != 0) void'(pend[i].pop_front());
      held = req_valid[i] && !last_hs[i];
      if (pend[i].size() != 0 && (held || !gaps || $urandom_range(3) != 0)) begin
        req_valid[i]        = 1'b1;
        req_data[i*5 +: 5]  = pend[i][0];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*5 +: 5]  = 5'($urandom);
      end
    end
    case (mode)
      0:       res_ready = 1'b1;
      1:       res_ready = ($urandom_range(3) != 0);
      2:       res_ready = !(n >= 3 && n <= 7);
      default: res_ready = 1'b0;
    endcase
  endtask

  task automatic drain(input bit gaps, input int mode, input int budget);
    int n = 0;
    bit empty;
    forever begin
      cycle(gaps, mode, n);
      n++;
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) empty = 1'b0;
      if (empty && sb.size() == 0) break;
      if (n >= budget) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: got %0d cycles want done within %0d", n, budget);
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request from requester 0
    pend[0].push_back(5'b00010);
    drain(1'b0, 0, 20);

    // Operand sweep on requester 2
    for (int v = 0; v < 32; v++) pend[2].push_back(5'(v));
    drain(1'b0, 0, 80);

    // Fairness with all requesters busy
    for (int i = 0; i < NREQ; i++) repeat (8) pend[i].push_back(5'($urandom));
    drain(1'b0, 0, 80);

    // Backpressure window
    for (int i = 0; i < NREQ; i++) repeat (6) pend[i].push_back(5'($urandom));
    drain(1'b0, 2, 80);

    // Random traffic; long enough to wrap done_cnt
    for (int j = 0; j < 300; j++) pend[$urandom_range(NREQ-1)].push_back(5'($urandom));
    drain(1'b1, 1, 3000);

    // Reset while both stages are full
    for (int i = 0; i < NREQ; i++) repeat (4) pend[i].push_back(5'($urandom));
    n = 0;
    do begin
      cycle(1'b0, 3, n);
      n++;
    end while (sb.size() < 2 && n < 20);
    chk("prefill_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done_cnt", 32'(done_cnt), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend[2].push_back(5'b00010);
    drain(1'b0, 0, 20);

    // Pointer restarts at requester 0 after reset
    pulse_reset();
    for (int i = 0; i < NREQ; i++) repeat (2) pend[i].push_back(5'($urandom));
    drain(1'b0, 0, 40);

    repeat (3) @(posedge clk);
    chk("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before t=2000000");
    $fatal(1, "watchdog");
  end

endmodule
